// File: rtl/epd_ingress_buffer.sv
// Store-and-forward frame buffer ahead of the packet detector: only whole frames are replayed, gap-free, with control high.
// First byte appears 2 cycles after a frame commits (reader idle); no input backpressure, a frame that overflows is dropped.
module epd_ingress_buffer #(
  parameter int DEPTH   = 128,
  parameter int MIN_GAP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic [7:0] data,
  output logic       control,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  logic [8:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   commit_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   occupancy;
  logic [AW:0]   pkt_pending;
  logic [GW-1:0] gap_cnt;
  state_t        state;
  logic          discard;
  logic          cur_last;
  logic [8:0]    rd_entry;
  logic          start;
  logic          rd_en;
  logic          wr_try;
  logic          full;
  logic          ovf_evt;
  logic          wr_en;
  logic          commit;

  // Pointers carry one extra bit so a full buffer is distinguishable from an empty one.
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign rd_entry  = mem[rd_ptr[AW-1:0]];

  assign start   = (state == IDLE) && (pkt_pending != '0);
  assign rd_en   = start || ((state == STREAM) && !cur_last);
  assign wr_try  = in_valid && !discard;
  // A read in the same cycle frees the slot, so a write at full only fails when nothing is read.
  assign ovf_evt = wr_try && full && !rd_en;
  assign wr_en   = wr_try && !ovf_evt;
  assign commit  = wr_en && in_last;
  assign busy    = (state == STREAM) || (state == GAP);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
    end
  end

  // Write side: working pointer, frame-start pointer, discard mode and drop accounting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      discard    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      overflow <= ovf_evt;
      if (ovf_evt) begin
        wr_ptr  <= commit_ptr;
        discard <= !in_last;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        if (in_last) begin
          commit_ptr <= wr_ptr + (AW+1)'(1);
        end
      end else if (in_valid && discard && in_last) begin
        discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_pending <= '0;
    end else begin
      case ({commit, start})
        2'b10:   pkt_pending <= pkt_pending + (AW+1)'(1);
        2'b01:   pkt_pending <= pkt_pending - (AW+1)'(1);
        default: pkt_pending <= pkt_pending;
      endcase
    end
  end

  // Read FSM: data/control are loaded on the same edge that advances rd_ptr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      data     <= 8'h00;
      control  <= 1'b0;
      cur_last <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          data    <= 8'h00;
          control <= 1'b0;
          if (start) begin
            data     <= rd_entry[7:0];
            cur_last <= rd_entry[8];
            control  <= 1'b1;
            rd_ptr   <= rd_ptr + (AW+1)'(1);
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (cur_last) begin
            data     <= 8'h00;
            control  <= 1'b0;
            cur_last <= 1'b0;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            data     <= rd_entry[7:0];
            cur_last <= rd_entry[8];
            control  <= 1'b1;
            rd_ptr   <= rd_ptr + (AW+1)'(1);
          end
        end
        GAP: begin
          data    <= 8'h00;
          control <= 1'b0;
          if (gap_cnt == GW'(MIN_GAP - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          data    <= 8'h00;
          control <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epd_ingress_buffer.sv
// Directed bench for epd_ingress_buffer: frame replay, gap timing, overflow drop, full-occupancy streaming, reset, saturation.
module tb_epd_ingress_buffer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] data;
  logic       control;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  int         ovf_cnt = 0;
  int         idle_nz = 0;
  logic [7:0] got_dat[$];
  int         got_cyc[$];
  logic [8:0] in_q[$];
  logic [7:0] exp_q[$];

  epd_ingress_buffer #(.DEPTH(128), .MIN_GAP(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .data       (data),
    .control    (control),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output monitor, sampled on the falling edge.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (control === 1'b1) begin
      got_dat.push_back(data);
      got_cyc.push_back(cyc);
    end else if (reset === 1'b1 && data !== 8'h00) begin
      idle_nz = idle_nz + 1;
    end
    if (overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    got_dat.delete();
    got_cyc.delete();
    exp_q.delete();
    ovf_cnt = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    reset    = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    clear_mon();
  endtask

  task automatic add_frame(input int len, input int base, input bit keep);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'(base + i);
      in_q.push_back({(i == len - 1), b});
      if (keep) exp_q.push_back(b);
    end
  endtask

  task automatic drive_q();
    foreach (in_q[i]) begin
      in_valid = 1'b1;
      in_data  = in_q[i][7:0];
      in_last  = in_q[i][8];
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_q.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    reset    = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++; if (data !== 8'h00)       begin errors++; $display("FAIL reset_data got=%h want=00", data); end
    checks++; if (control !== 1'b0)     begin errors++; $display("FAIL reset_control got=%b want=0", control); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL reset_drop_count got=%h want=00", drop_count); end
    tick(3);
    reset = 1'b1;
    tick(2);
    clear_mon();
  endtask

  task automatic test_single_frame();
    int t0;
    do_reset();
    add_frame(8, 8'h01, 1'b1);
    drive_q();
    t0 = cyc;
    tick(20);
    checks++; if (got_dat.size() != 8) begin errors++; $display("FAIL single_len got=%0d want=8", got_dat.size()); end
    for (int i = 0; i < 8 && i < got_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]); end
    end
    if (got_cyc.size() == 8) begin
      checks++; if (got_cyc[0] != t0 + 2) begin errors++; $display("FAIL single_latency got=%0d want=%0d", got_cyc[0] - t0, 2); end
      checks++; if (got_cyc[7] - got_cyc[0] != 7) begin errors++; $display("FAIL single_contig got=%0d want=7", got_cyc[7] - got_cyc[0]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_frame(64, 8'h40, 1'b1);
    add_frame(64, 8'h80, 1'b1);
    drive_q();
    tick(120);
    checks++; if (got_dat.size() != 128) begin errors++; $display("FAIL b2b_len got=%0d want=128", got_dat.size()); end
    for (int i = 0; i < 128 && i < got_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]); end
    end
    if (got_cyc.size() == 128) begin
      checks++; if (got_cyc[63] - got_cyc[0] != 63)   begin errors++; $display("FAIL b2b_contig_a got=%0d want=63", got_cyc[63] - got_cyc[0]); end
      checks++; if (got_cyc[64] - got_cyc[63] - 1 != 3) begin errors++; $display("FAIL b2b_gap got=%0d want=3", got_cyc[64] - got_cyc[63] - 1); end
      checks++; if (got_cyc[127] - got_cyc[64] != 63) begin errors++; $display("FAIL b2b_contig_b got=%0d want=63", got_cyc[127] - got_cyc[64]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    add_frame(130, 0, 1'b0);
    drive_q();
    tick(20);
    checks++; if (got_dat.size() != 0)  begin errors++; $display("FAIL ovf_emitted got=%0d want=0", got_dat.size()); end
    checks++; if (ovf_cnt != 1)         begin errors++; $display("FAIL ovf_pulses got=%0d want=1", ovf_cnt); end
    checks++; if (drop_count !== 8'h01) begin errors++; $display("FAIL ovf_drop_count got=%h want=01", drop_count); end
    add_frame(10, 8'hA0, 1'b1);
    drive_q();
    tick(30);
    checks++; if (got_dat.size() != 10) begin errors++; $display("FAIL ovf_next_len got=%0d want=10", got_dat.size()); end
    for (int i = 0; i < 10 && i < got_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_next_byte[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]); end
    end
  endtask

  // Short frames starve the reader with gaps so occupancy climbs to exactly DEPTH just as the 100-byte frame starts.
  task automatic test_full_stream();
    do_reset();
    add_frame(2, 8'h10, 1'b1);
    for (int j = 0; j < 41; j++) add_frame(1, 8'h20 + j, 1'b1);
    add_frame(100, 8'h00, 1'b1);
    add_frame(64, 8'hC0, 1'b1);
    drive_q();
    tick(300);
    checks++; if (got_dat.size() != 207) begin errors++; $display("FAIL full_len got=%0d want=207", got_dat.size()); end
    for (int i = 0; i < 207 && i < got_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_q[i]) begin errors++; $display("FAIL full_byte[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]); end
    end
    if (got_cyc.size() == 207) begin
      checks++; if (got_cyc[142] - got_cyc[43] != 99) begin errors++; $display("FAIL full_contig got=%0d want=99", got_cyc[142] - got_cyc[43]); end
    end
    checks++; if (ovf_cnt != 0)         begin errors++; $display("FAIL full_ovf got=%0d want=0", ovf_cnt); end
    checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL full_drop_count got=%h want=00", drop_count); end
  endtask

  task automatic test_reset_mid_stream();
    int n;
    do_reset();
    add_frame(130, 0, 1'b0);
    drive_q();
    tick(5);
    add_frame(60, 8'h30, 1'b1);
    drive_q();
    n = 0;
    while (got_dat.size() < 20 && n < 200) begin
      tick(1);
      n++;
    end
    checks++; if (got_dat.size() < 20) begin errors++; $display("FAIL mid_reach20 got=%0d want>=20", got_dat.size()); end
    checks++; if (drop_count !== 8'h01) begin errors++; $display("FAIL mid_pre_drop got=%h want=01", drop_count); end
    reset = 1'b0;
    #1;
    checks++; if (control !== 1'b0)     begin errors++; $display("FAIL mid_control got=%b want=0", control); end
    checks++; if (data !== 8'h00)       begin errors++; $display("FAIL mid_data got=%h want=00", data); end
    checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL mid_drop_count got=%h want=00", drop_count); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
    tick(2);
    reset = 1'b1;
    tick(1);
    clear_mon();
    tick(100);
    checks++; if (got_dat.size() != 0) begin errors++; $display("FAIL mid_quiet got=%0d want=0", got_dat.size()); end
    add_frame(5, 8'hE0, 1'b1);
    drive_q();
    tick(20);
    checks++; if (got_dat.size() != 5) begin errors++; $display("FAIL mid_new_len got=%0d want=5", got_dat.size()); end
    for (int i = 0; i < 5 && i < got_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_q[i]) begin errors++; $display("FAIL mid_new_byte[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      add_frame(130, k, 1'b0);
      drive_q();
      if (k == 128) begin
        checks++; if (drop_count !== 8'h80) begin errors++; $display("FAIL sat_128 got=%h want=80", drop_count); end
      end
      if (k == 255) begin
        checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_255 got=%h want=ff", drop_count); end
      end
    end
    tick(10);
    checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_256 got=%h want=ff", drop_count); end
    checks++; if (ovf_cnt != 256)       begin errors++; $display("FAIL sat_pulses got=%0d want=256", ovf_cnt); end
    checks++; if (got_dat.size() != 0)  begin errors++; $display("FAIL sat_emitted got=%0d want=0", got_dat.size()); end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_stream();
    test_reset_mid_stream();
    test_saturate();
    checks++; if (idle_nz != 0) begin errors++; $display("FAIL idle_data_nonzero got=%0d want=0", idle_nz); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
